vc_zeilen_lader: RTL
====================

Name: vc_zeilen_lader

Overview:
Video-line prefetch sequencer feeding the VC request port of the RAM arbiter (RAMSteuerung).
- On each scanline start it issues WORTE_PRO_ZEILE consecutive 32-bit word reads via the VCAdresse/VCLesen/VCFertig/DatenAusgabe handshake.
- It writes each returned word into one bank of an external double-buffered line RAM, then signals line completion.
- Display logic reads the opposite bank.

Parameters:
WORTE_PRO_ZEILE, 160, 32-bit words fetched per line (1..2^PUFFER_ADR_BREITE).
ADR_BREITE, 23, word-address width of the RAM arbiter port.
PUFFER_ADR_BREITE, 8, line-buffer word-index width.

Ports:
Clock  in  1  system clock, all logic on rising edge.
Reset  in  1  synchronous, active-low reset.
ZeileStart  in  1  one-cycle pulse: begin fetching a line.
ZeilenAdresse  in  ADR_BREITE  base word address of the line; sampled with ZeileStart.
UeberlaufLoeschen  in  1  clears the sticky Ueberlauf flag.
VCAdresse  out  ADR_BREITE  word address to the arbiter.
VCLesen  out  1  read request to the arbiter.
VCFertig  in  1  arbiter completion pulse; DatenAusgabe valid in the same cycle.
DatenAusgabe  in  32  read data from the arbiter.
PufferSchreiben  out  1  line-buffer write strobe.
PufferBank  out  1  bank currently being filled.
PufferAdresse  out  PUFFER_ADR_BREITE  word index inside the bank.
PufferDaten  out  32  write data.
Beschaeftigt  out  1  high while not in LEERLAUF.
ZeileFertig  out  1  one-cycle pulse after the last word is written.
Ueberlauf  out  1  sticky: ZeileStart arrived while busy.

Behaviour:
- Reset (Reset=0 at a rising edge) sets every output and register to 0 and the state to LEERLAUF, including mid-request. VCLesen is low from the next edge. The arbiter must tolerate an abandoned request.
- States:
  - LEERLAUF: on ZeileStart, latch Basis<=ZeilenAdresse, Zaehler<=0, PufferBank<=~PufferBank, then go to ANFRAGE.
  - ANFRAGE: VCLesen=1 and VCAdresse=Basis+Zaehler, held stable until VCFertig. On VCFertig (registered outputs, next cycle):
    - PufferSchreiben=1, PufferAdresse=Zaehler, PufferDaten=DatenAusgabe.
    - VCLesen=0.
    - If Zaehler==WORTE_PRO_ZEILE-1: go to LEERLAUF and pulse ZeileFertig in that same write cycle.
    - Otherwise: Zaehler+=1 and go to PAUSE.
  - PAUSE: exactly one cycle with VCLesen=0, then go to ANFRAGE.
- VCLesen is never high in two consecutive requests without a low cycle between them. There is at least one idle cycle after each VCFertig.
- Address arithmetic is modulo 2^ADR_BREITE: base 0x7FFFFF wraps to 0x000000. No carry or flag.
- VCFertig while VCLesen=0 (LEERLAUF/PAUSE) is ignored.
- ZeileStart outside LEERLAUF is ignored; Ueberlauf<=1. The current line continues unchanged.
- ZeileStart in the cycle that returns to LEERLAUF is already busy, so it is an overrun.
- UeberlaufLoeschen and a new overrun in the same cycle: overrun wins, Ueberlauf stays 1.
- PufferSchreiben and ZeileFertig are single-cycle pulses, 0 otherwise.
- PufferDaten holds its last value between writes.
- Beschaeftigt is registered with state and is 1 in ANFRAGE and PAUSE.
- Latency per word: VCFertig → write strobe next edge; next VCLesen two edges after VCFertig.
- PufferBank toggles only on an accepted start. After reset the first line fills bank 1.

Decomposition:
- Shared package vc_pkg: state encoding (LEERLAUF=0, ANFRAGE=1, PAUSE=2), ADR_BREITE and default WORTE_PRO_ZEILE constants.
- Single module; no sub-module needed. An optional tiny sticky-flag cell is not worth separating.

Test Plan:
1. Reset, ZeileStart with ZeilenAdresse=0x001000 and WORTE_PRO_ZEILE=4; arbiter model answers VCFertig 3 cycles after VCLesen with data 0xA0000000+addr → VCAdresse 0x001000..0x001003 in order, 4 writes at PufferAdresse 0..3 with matching data, PufferBank=1, single ZeileFertig on the 4th write, Beschaeftigt falls at the same time.
2. Two back-to-back lines (0x000000, then 0x000100) → PufferBank 1 then 0, VCLesen low ≥1 cycle between every request.
3. ZeilenAdresse=0x7FFFFE with 4 words → addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
4. ZeileStart during word 2 → Ueberlauf=1, fetch sequence unchanged. UeberlaufLoeschen → 0. Clear and overrun together → stays 1.
5. Reset=0 while VCLesen=1 mid-line → next cycle all outputs 0, LEERLAUF; a new ZeileStart restarts at Zaehler 0 and bank 1.
6. Spurious VCFertig in LEERLAUF and PAUSE → no write, no state change.

Source files
------------

// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared state encoding and default sizes for the video line loader
package vc_pkg;

    localparam int ADR_BREITE_DEF        = 23;
    localparam int WORTE_PRO_ZEILE_DEF   = 160;
    localparam int PUFFER_ADR_BREITE_DEF = 8;

    typedef enum logic [1:0] {
        LEERLAUF = 2'd0,
        ANFRAGE  = 2'd1,
        PAUSE    = 2'd2
    } zustand_t;

endpackage

// File: rtl/vc_zeilen_lader.sv
// rtl/vc_zeilen_lader.sv - per-scanline word prefetch from the RAM arbiter into a double-buffered line RAM
module vc_zeilen_lader
    import vc_pkg::*;
#(
    parameter int WORTE_PRO_ZEILE   = WORTE_PRO_ZEILE_DEF,
    parameter int ADR_BREITE        = ADR_BREITE_DEF,
    parameter int PUFFER_ADR_BREITE = PUFFER_ADR_BREITE_DEF
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         ZeileStart,
    input  logic [ADR_BREITE-1:0]        ZeilenAdresse,
    input  logic                         UeberlaufLoeschen,
    output logic [ADR_BREITE-1:0]        VCAdresse,
    output logic                         VCLesen,
    input  logic                         VCFertig,
    input  logic [31:0]                  DatenAusgabe,
    output logic                         PufferSchreiben,
    output logic                         PufferBank,
    output logic [PUFFER_ADR_BREITE-1:0] PufferAdresse,
    output logic [31:0]                  PufferDaten,
    output logic                         Beschaeftigt,
    output logic                         ZeileFertig,
    output logic                         Ueberlauf
);

    localparam logic [PUFFER_ADR_BREITE-1:0] LETZTES = PUFFER_ADR_BREITE'(WORTE_PRO_ZEILE - 1);

    zustand_t                     state_q, state_d;
    logic [ADR_BREITE-1:0]        basis_q, basis_d;
    logic [PUFFER_ADR_BREITE-1:0] zaehler_q, zaehler_d;
    logic                         bank_q, bank_d;
    logic                         schreiben_q, schreiben_d;
    logic [PUFFER_ADR_BREITE-1:0] padr_q, padr_d;
    logic [31:0]                  pdaten_q, pdaten_d;
    logic                         fertig_q, fertig_d;
    logic                         ueber_q, ueber_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= LEERLAUF;
            basis_q     <= '0;
            zaehler_q   <= '0;
            bank_q      <= 1'b0;
            schreiben_q <= 1'b0;
            padr_q      <= '0;
            pdaten_q    <= '0;
            fertig_q    <= 1'b0;
            ueber_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            basis_q     <= basis_d;
            zaehler_q   <= zaehler_d;
            bank_q      <= bank_d;
            schreiben_q <= schreiben_d;
            padr_q      <= padr_d;
            pdaten_q    <= pdaten_d;
            fertig_q    <= fertig_d;
            ueber_q     <= ueber_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        basis_d     = basis_q;
        zaehler_d   = zaehler_q;
        bank_d      = bank_q;
        schreiben_d = 1'b0;
        padr_d      = padr_q;
        pdaten_d    = pdaten_q;
        fertig_d    = 1'b0;
        ueber_d     = ueber_q;

        if (UeberlaufLoeschen) begin
            ueber_d = 1'b0;
        end

        case (state_q)
            LEERLAUF: begin
                if (ZeileStart) begin
                    basis_d   = ZeilenAdresse;
                    zaehler_d = '0;
                    bank_d    = ~bank_q;
                    state_d   = ANFRAGE;
                end
            end
            ANFRAGE: begin
                if (VCFertig) begin
                    schreiben_d = 1'b1;
                    padr_d      = zaehler_q;
                    pdaten_d    = DatenAusgabe;
                    if (zaehler_q == LETZTES) begin
                        fertig_d = 1'b1;
                        state_d  = LEERLAUF;
                    end else begin
                        zaehler_d = zaehler_q + PUFFER_ADR_BREITE'(1);
                        state_d   = PAUSE;
                    end
                end
            end
            PAUSE: begin
                state_d = ANFRAGE;
            end
            default: begin
                state_d = LEERLAUF;
            end
        endcase

        // A start while busy (including the final write cycle) is an overrun and beats a clear.
        if (ZeileStart && (state_q != LEERLAUF)) begin
            ueber_d = 1'b1;
        end
    end

    assign VCLesen         = (state_q == ANFRAGE);
    assign VCAdresse       = basis_q + ADR_BREITE'(zaehler_q);
    assign Beschaeftigt    = (state_q != LEERLAUF);
    assign PufferSchreiben = schreiben_q;
    assign PufferBank      = bank_q;
    assign PufferAdresse   = padr_q;
    assign PufferDaten     = pdaten_q;
    assign ZeileFertig     = fertig_q;
    assign Ueberlauf       = ueber_q;

endmodule
